// File: rtl/gomoku_controller.sv
// Gomoku game sequencer for a 16x16 board. It tracks the cursor, places stones,
// keeps the turn and game status, and runs a multi-cycle five-in-a-row scan after each move.
module gomoku_controller #(
    parameter int BOARD_N = 16,
    parameter int WIN_LEN = 5
) (
    input  logic         Clck,
    input  logic         Reset,
    input  logic         Key_up,
    input  logic         Key_down,
    input  logic         Key_left,
    input  logic         Key_right,
    input  logic         Key_place,
    output logic [511:0] board,
    output logic [1:0]   gaming_status,
    output logic [15:0]  pointer_loc_x,
    output logic [15:0]  pointer_loc_y,
    output logic [1:0]   current_player,
    output logic         busy
);

    typedef enum logic [2:0] {
        IDLE,
        SCAN_FWD,
        SCAN_BWD,
        NEXT_DIR,
        FINISH,
        OVER
    } state_t;

    localparam logic [3:0] EDGE_MAX = 4'(BOARD_N - 1);
    localparam logic [2:0] WIN_CNT  = 3'(WIN_LEN);

    state_t            state;
    logic [4:0]        key_now;
    logic [4:0]        key_prev;
    logic [4:0]        key_edge;
    logic [3:0]        px;
    logic [3:0]        py;
    logic [3:0]        ox;
    logic [3:0]        oy;
    logic [1:0]        colour;
    logic [1:0]        dir;
    logic [2:0]        count;
    logic [2:0]        count_inc;
    logic [8:0]        moves;
    logic              win;
    logic signed [4:0] cx;
    logic signed [4:0] cy;
    logic signed [4:0] step_x;
    logic signed [4:0] step_y;
    logic signed [4:0] nx;
    logic signed [4:0] ny;
    logic [8:0]        next_idx;
    logic [8:0]        ptr_idx;
    logic [1:0]        next_cell;
    logic [1:0]        ptr_cell;
    logic              match;

    assign key_now  = {Key_place, Key_up, Key_down, Key_left, Key_right};
    assign key_edge = key_now & ~key_prev;

    assign pointer_loc_x = {12'd0, px};
    assign pointer_loc_y = {12'd0, py};

    // The step vector for the current direction. The backward scan uses the
    // negated vector and restarts from the origin.
    always_comb begin
        step_x = 5'sd0;
        step_y = 5'sd0;
        case (dir)
            2'd0:    begin step_x = 5'sd1; step_y = 5'sd0;  end
            2'd1:    begin step_x = 5'sd0; step_y = 5'sd1;  end
            2'd2:    begin step_x = 5'sd1; step_y = 5'sd1;  end
            default: begin step_x = 5'sd1; step_y = -5'sd1; end
        endcase
        if (state == SCAN_BWD) begin
            step_x = -step_x;
            step_y = -step_y;
        end
    end

    // Coordinates stay within 0..15, so one step lands in -1..16. Both -1
    // (11111) and 16 (10000 wraps to -16) have bit 4 set, which makes that
    // bit the out-of-bounds flag.
    assign nx        = cx + step_x;
    assign ny        = cy + step_y;
    assign next_idx  = {ny[3:0], nx[3:0], 1'b0};
    assign ptr_idx   = {py, px, 1'b0};
    assign next_cell = board[next_idx +: 2];
    assign ptr_cell  = board[ptr_idx +: 2];
    assign match     = !nx[4] && !ny[4] && (next_cell == colour);
    assign count_inc = (count == WIN_CNT) ? count : count + 3'd1;

    // Controller state machine. It handles key actions in IDLE, steps the scan
    // one cell per cycle, and resolves the move in FINISH.
    always_ff @(posedge Clck) begin
        if (!Reset) begin
            state          <= IDLE;
            board          <= '0;
            gaming_status  <= 2'b00;
            px             <= 4'd7;
            py             <= 4'd7;
            ox             <= 4'd0;
            oy             <= 4'd0;
            cx             <= 5'sd0;
            cy             <= 5'sd0;
            colour         <= 2'b00;
            dir            <= 2'd0;
            count          <= 3'd0;
            moves          <= 9'd0;
            win            <= 1'b0;
            current_player <= 2'b01;
            busy           <= 1'b0;
            key_prev       <= 5'b0;
        end else begin
            key_prev <= key_now;
            case (state)
                IDLE: begin
                    if (gaming_status == 2'b00) begin
                        if (key_edge[4]) begin
                            if (ptr_cell == 2'b00) begin
                                board[ptr_idx +: 2] <= current_player;
                                ox     <= px;
                                oy     <= py;
                                cx     <= {1'b0, px};
                                cy     <= {1'b0, py};
                                colour <= current_player;
                                count  <= 3'd1;
                                dir    <= 2'd0;
                                win    <= 1'b0;
                                busy   <= 1'b1;
                                state  <= SCAN_FWD;
                            end
                        end else if (key_edge[3]) begin
                            if (py != 4'd0) py <= py - 4'd1;
                        end else if (key_edge[2]) begin
                            if (py != EDGE_MAX) py <= py + 4'd1;
                        end else if (key_edge[1]) begin
                            if (px != 4'd0) px <= px - 4'd1;
                        end else if (key_edge[0]) begin
                            if (px != EDGE_MAX) px <= px + 4'd1;
                        end
                    end
                end
                SCAN_FWD, SCAN_BWD: begin
                    if (match) begin
                        count <= count_inc;
                        cx    <= nx;
                        cy    <= ny;
                        if (count_inc == WIN_CNT) begin
                            win   <= 1'b1;
                            state <= FINISH;
                        end
                    end else begin
                        cx    <= {1'b0, ox};
                        cy    <= {1'b0, oy};
                        state <= (state == SCAN_FWD) ? SCAN_BWD : NEXT_DIR;
                    end
                end
                NEXT_DIR: begin
                    if (dir == 2'd3) begin
                        win   <= 1'b0;
                        state <= FINISH;
                    end else begin
                        dir   <= dir + 2'd1;
                        count <= 3'd1;
                        cx    <= {1'b0, ox};
                        cy    <= {1'b0, oy};
                        state <= SCAN_FWD;
                    end
                end
                FINISH: begin
                    busy <= 1'b0;
                    if (win) begin
                        gaming_status <= colour;
                        state         <= OVER;
                    end else begin
                        moves <= moves + 9'd1;
                        if (moves == 9'd255) begin
                            gaming_status <= 2'b11;
                            state         <= OVER;
                        end else begin
                            current_player <= ~current_player;
                            state          <= IDLE;
                        end
                    end
                end
                OVER: begin
                    state <= OVER;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gomoku_controller.sv
// Directed bench for gomoku_controller. A cursor vector table is followed by
// hand-written game sequences covering wins, blocked lines and reset mid-scan.
module tb_gomoku_controller;

    logic         clk;
    logic         rst_n;
    logic         key_up;
    logic         key_down;
    logic         key_left;
    logic         key_right;
    logic         key_place;
    logic [511:0] board;
    logic [1:0]   gaming_status;
    logic [15:0]  pointer_loc_x;
    logic [15:0]  pointer_loc_y;
    logic [1:0]   current_player;
    logic         busy;

    int errors = 0;
    int checks = 0;
    int cur_x  = 7;
    int cur_y  = 7;
    logic [1:0] model_player = 2'b01;

    // Key order in vectors: {place, up, down, left, right}
    typedef struct {
        logic [4:0] keys;
        int         reps;
        int         hold;
        int         exp_x;
        int         exp_y;
    } vec_t;

    vec_t vecs[8];

    gomoku_controller #(.BOARD_N(16), .WIN_LEN(5)) dut (
        .Clck           (clk),
        .Reset          (rst_n),
        .Key_up         (key_up),
        .Key_down       (key_down),
        .Key_left       (key_left),
        .Key_right      (key_right),
        .Key_place      (key_place),
        .board          (board),
        .gaming_status  (gaming_status),
        .pointer_loc_x  (pointer_loc_x),
        .pointer_loc_y  (pointer_loc_y),
        .current_player (current_player),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Keys are driven at the falling edge, held for 'hold' cycles, then released for one cycle.
    task automatic applyStimulus(input logic [4:0] k, input int hold);
        {key_place, key_up, key_down, key_left, key_right} = k;
        repeat (hold) @(negedge clk);
        {key_place, key_up, key_down, key_left, key_right} = 5'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        {key_place, key_up, key_down, key_left, key_right} = 5'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cur_x = 7;
        cur_y = 7;
        model_player = 2'b01;
    endtask

    task automatic move_to(input int x, input int y);
        while (cur_x > x) begin applyStimulus(5'b00010, 1); cur_x--; end
        while (cur_x < x) begin applyStimulus(5'b00001, 1); cur_x++; end
        while (cur_y > y) begin applyStimulus(5'b01000, 1); cur_y--; end
        while (cur_y < y) begin applyStimulus(5'b00100, 1); cur_y++; end
        checkOutput("move_ptr", {pointer_loc_y, pointer_loc_x}, {16'(y), 16'(x)});
    endtask

    // This task places a stone, waits for the scan to finish and checks the resulting status.
    task automatic place_at(input int x, input int y, input logic [1:0] exp_status);
        int n;
        move_to(x, y);
        key_place = 1'b1;
        @(posedge clk);
        #1;
        key_place = 1'b0;
        checkOutput("placed_cell", 512'(board[x*2 + y*32 +: 2]), 512'(model_player));
        checkOutput("busy_rise", 512'(busy), 512'(1'b1));
        n = 0;
        while (busy && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("busy_timeout", 512'(busy), 512'(1'b0));
        checkOutput("latency_le_45", 512'(n <= 45), 512'(1'b1));
        checkOutput("status", 512'(gaming_status), 512'(exp_status));
        if (exp_status == 2'b00) model_player = ~model_player;
        checkOutput("player", 512'(current_player), 512'(model_player));
        @(negedge clk);
    endtask

    initial begin
        logic [511:0] saved;
        logic [511:0] expect_board;

        vecs[0] = '{5'b00010, 10, 1,   0,  7};
        vecs[1] = '{5'b00001, 20, 1,  15,  7};
        vecs[2] = '{5'b00100,  1, 100, 15, 8};
        vecs[3] = '{5'b01010,  1, 1,  15,  7};
        vecs[4] = '{5'b01000, 10, 1,  15,  0};
        vecs[5] = '{5'b00100, 20, 1,  15, 15};
        vecs[6] = '{5'b00011,  1, 1,  14, 15};
        vecs[7] = '{5'b00101,  1, 1,  14, 15};

        {key_place, key_up, key_down, key_left, key_right} = 5'b0;
        rst_n = 1'b0;
        @(negedge clk);
        do_reset();
        checkOutput("reset_board", board, '0);
        checkOutput("reset_status", 512'(gaming_status), 512'(2'b00));
        checkOutput("reset_ptr", {pointer_loc_y, pointer_loc_x}, {16'd7, 16'd7});
        checkOutput("reset_player", 512'(current_player), 512'(2'b01));
        checkOutput("reset_busy", 512'(busy), 512'(1'b0));

        // Cursor vectors: clamping, held keys and same-cycle priority
        for (int i = 0; i < 8; i++) begin
            for (int r = 0; r < vecs[i].reps; r++) applyStimulus(vecs[i].keys, vecs[i].hold);
            checkOutput($sformatf("vec%0d_ptr", i), {pointer_loc_y, pointer_loc_x},
                        {16'(vecs[i].exp_y), 16'(vecs[i].exp_x)});
        end
        cur_x = 14;
        cur_y = 15;

        // Placement and occupancy
        do_reset();
        place_at(7, 7, 2'b00);
        expect_board = '0;
        expect_board[239:238] = 2'b01;
        checkOutput("first_place_board", board, expect_board);
        saved = board;
        applyStimulus(5'b10000, 1);
        repeat (3) @(negedge clk);
        checkOutput("occupied_board", board, saved);
        checkOutput("occupied_player", 512'(current_player), 512'(2'b10));
        checkOutput("occupied_busy", 512'(busy), 512'(1'b0));

        // Horizontal win on the top edge with the last stone at the open end
        do_reset();
        for (int i = 0; i < 4; i++) begin
            place_at(15 - i, 0, 2'b00);
            place_at(i, 15, 2'b00);
        end
        place_at(11, 0, 2'b01);
        saved = board;
        applyStimulus(5'b10000, 1);
        applyStimulus(5'b00010, 1);
        applyStimulus(5'b01000, 1);
        checkOutput("over_board", board, saved);
        checkOutput("over_ptr", {pointer_loc_y, pointer_loc_x}, {16'd0, 16'd11});
        checkOutput("over_status", 512'(gaming_status), 512'(2'b01));

        // Anti-diagonal win for player 2, completed by the backward scan
        do_reset();
        place_at(0, 9, 2'b00);
        place_at(4, 4, 2'b00);
        place_at(2, 9, 2'b00);
        place_at(5, 3, 2'b00);
        place_at(4, 9, 2'b00);
        place_at(6, 2, 2'b00);
        place_at(6, 9, 2'b00);
        place_at(7, 1, 2'b00);
        place_at(8, 9, 2'b00);
        place_at(8, 0, 2'b10);

        // Four stones against the right edge with a same-colour stone at (0,6),
        // plus a mixed-colour row of five
        do_reset();
        place_at(12, 5, 2'b00);
        place_at(9, 9, 2'b00);
        place_at(13, 5, 2'b00);
        place_at(10, 9, 2'b00);
        place_at(14, 5, 2'b00);
        place_at(12, 9, 2'b00);
        place_at(11, 9, 2'b00);
        place_at(3, 3, 2'b00);
        place_at(0, 6, 2'b00);
        place_at(13, 9, 2'b00);
        place_at(15, 5, 2'b00);

        // Reset mid-scan
        do_reset();
        key_place = 1'b1;
        @(posedge clk);
        @(negedge clk);
        key_place = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midscan_busy", 512'(busy), 512'(1'b0));
        checkOutput("midscan_board", board, '0);
        checkOutput("midscan_status", 512'(gaming_status), 512'(2'b00));
        @(negedge clk);
        rst_n = 1'b1;
        cur_x = 7;
        cur_y = 7;
        model_player = 2'b01;
        place_at(7, 7, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
